// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ALU control decode and operand-B select,
// presented to execute through a registered 2-entry skid buffer.
module alu_issue_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_alu_op,
  input  logic [5:0]            in_opcode,
  input  logic [5:0]            in_funct,
  input  logic                  in_alu_src,
  input  logic [DATA_WIDTH-1:0] in_rs_data,
  input  logic [DATA_WIDTH-1:0] in_rt_data,
  input  logic [15:0]           in_imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_control,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic                  out_illegal,
  output logic [CNT_WIDTH-1:0]  illegal_count
);

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  typedef struct packed {
    logic [3:0]            control;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  illegal;
  } entry_t;

  logic [1:0] count;
  entry_t     head;
  entry_t     tail;
  entry_t     dec;
  entry_t     shown;
  logic       push;
  logic       pop;
  logic       zext;
  logic       sat;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // logical immediates (andi/ori) zero-extend, everything else sign-extends
  assign zext = (in_opcode == 6'b001100) |
                (in_opcode == 6'b001101);

  always_comb begin
    dec         = '0;
    dec.control = CTL_ADD;
    dec.a       = in_rs_data;
    unique case (in_alu_op)
      2'b00: dec.control = CTL_ADD;
      2'b01: dec.control = CTL_SUB;
      2'b10: begin
        case (in_funct)
          6'b100000: dec.control = CTL_ADD;
          6'b100010: dec.control = CTL_SUB;
          6'b100100: dec.control = CTL_AND;
          6'b100101: dec.control = CTL_OR;
          6'b100111: dec.control = CTL_NOR;
          6'b101010: dec.control = CTL_SLT;
          default:   dec.illegal = 1'b1;
        endcase
      end
      2'b11: begin
        case (in_opcode)
          6'b001000: dec.control = CTL_ADD;
          6'b001100: dec.control = CTL_AND;
          6'b001101: dec.control = CTL_OR;
          6'b001010: dec.control = CTL_SLT;
          default:   dec.illegal = 1'b1;
        endcase
      end
    endcase
    unique case (1'b1)
      !in_alu_src:
        dec.b = in_rt_data;
      in_alu_src & zext:
        dec.b = {{(DATA_WIDTH-16){1'b0}}, in_imm};
      in_alu_src & !zext:
        dec.b = {{(DATA_WIDTH-16){in_imm[15]}}, in_imm};
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= dec;
          else               tail <= dec;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        // push+pop only possible at occupancy 1
        2'b11: head <= dec;
        default: ;
      endcase
    end
  end

  assign sat = &illegal_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      illegal_count <= '0;
    end else if (!flush && push && dec.illegal && !sat) begin
      illegal_count <= illegal_count + CNT_ONE;
    end
  end

  assign shown       = out_valid ? head : '0;
  assign out_control = shown.control;
  assign out_a       = shown.a;
  assign out_b       = shown.b;
  assign out_illegal = shown.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: scoreboard bench for alu_issue_stage
// with a table-driven reference model and randomized traffic.
module tb_alu_issue_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_alu_op;
  logic [5:0]  in_opcode;
  logic [5:0]  in_funct;
  logic        in_alu_src;
  logic [31:0] in_rs_data;
  logic [31:0] in_rt_data;
  logic [15:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_control;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic        out_illegal;
  logic [7:0]  illegal_count;

  alu_issue_stage #(.DATA_WIDTH(32), .CNT_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_op(in_alu_op), .in_opcode(in_opcode),
    .in_funct(in_funct), .in_alu_src(in_alu_src),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_imm(in_imm), .out_valid(out_valid),
    .out_ready(out_ready), .out_control(out_control),
    .out_a(out_a), .out_b(out_b),
    .out_illegal(out_illegal), .illegal_count(illegal_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   ill_model = 0;
  int   funct_map[int];
  int   op_map[int];

  bit   pend = 0;
  bit   pend_flush = 0;
  exp_t pend_e;
  bit   prev_hold = 0;
  exp_t prev_out;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // reference: table lookups from the opcode/funct encoding rules
  function automatic exp_t model(input logic [1:0] op,
      input logic [5:0] opc, input logic [5:0] fn,
      input logic src, input logic [31:0] rs,
      input logic [31:0] rt, input logic [15:0] imm);
    exp_t e;
    int   v;
    e.a = rs;
    e.ill = 1'b0;
    e.c = 4'd2;
    if (op == 2'd1) e.c = 4'd6;
    if (op == 2'd2) begin
      if (funct_map.exists(int'(fn))) e.c = 4'(funct_map[int'(fn)]);
      else e.ill = 1'b1;
    end
    if (op == 2'd3) begin
      if (op_map.exists(int'(opc))) e.c = 4'(op_map[int'(opc)]);
      else e.ill = 1'b1;
    end
    v = int'(imm);
    if (opc != 6'd12 && opc != 6'd13 && v >= 32768) v -= 65536;
    e.b = src ? 32'(v) : rt;
    return e;
  endfunction

  // predictor: sample handshake away from the edge, commit at the edge
  always @(negedge clock) begin
    pend = !reset && in_valid && in_ready && !flush;
    pend_flush = !reset && flush;
    pend_e = model(in_alu_op, in_opcode, in_funct, in_alu_src,
                   in_rs_data, in_rt_data, in_imm);
  end

  always @(posedge clock) begin
    if (!reset) begin
      if (pend_flush) q.delete();
      else if (pend) begin
        q.push_back(pend_e);
        if (pend_e.ill && ill_model < 255) ill_model++;
      end
    end
    pend = 0;
    pend_flush = 0;
  end

  // monitor
  always @(negedge clock) begin
    exp_t cur;
    exp_t e;
    cur = {out_control, out_a, out_b, out_illegal};
    if (!reset) begin
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("illegal_count", 64'(illegal_count), 64'(ill_model));
      if (!out_valid) chk("idle_zero", 64'(cur != '0), 64'd0);
      if (prev_hold) chk("hold_stable", 64'(cur == prev_out), 64'd1);
      if (out_valid && out_ready && !flush) begin
        if (q.size() == 0) begin
          chk("pop_unexpected", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("pop_control", 64'(out_control), 64'(e.c));
          chk("pop_a", 64'(out_a), 64'(e.a));
          chk("pop_b", 64'(out_b), 64'(e.b));
          chk("pop_illegal", 64'(out_illegal), 64'(e.ill));
        end
      end
      prev_hold = out_valid && !out_ready && !flush;
      prev_out = cur;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [5:0] opc,
      input logic [5:0] fn, input logic src, input logic [31:0] rs,
      input logic [31:0] rt, input logic [15:0] imm);
    in_alu_op = op;
    in_opcode = opc;
    in_funct = fn;
    in_alu_src = src;
    in_rs_data = rs;
    in_rt_data = rt;
    in_imm = imm;
    in_valid = 1'b1;
  endtask

  task automatic wait_acc();
    bit acc;
    acc = 0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clock);
      acc = in_ready && !flush && !reset;
      step();
    end
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic push(input logic [1:0] op, input logic [5:0] opc,
      input logic [5:0] fn, input logic src, input logic [31:0] rs,
      input logic [31:0] rt, input logic [15:0] imm);
    drive(op, opc, fn, src, rs, rt, imm);
    wait_acc();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  function automatic logic [5:0] pick_fn();
    logic [5:0] legal[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a};
    if ($urandom % 4 == 0) return 6'($urandom);
    return legal[$urandom % 6];
  endfunction

  function automatic logic [5:0] pick_opc();
    logic [5:0] legal[4] = '{6'h08, 6'h0c, 6'h0d, 6'h0a};
    if ($urandom % 4 == 0) return 6'($urandom);
    return legal[$urandom % 4];
  endfunction

  initial begin
    funct_map[32] = 2; funct_map[34] = 6; funct_map[36] = 0;
    funct_map[37] = 1; funct_map[39] = 12; funct_map[42] = 7;
    op_map[8] = 2; op_map[12] = 0; op_map[13] = 1; op_map[10] = 7;

    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(2'd0, 6'd0, 6'd0, 1'b0, 32'd0, 32'd0, 16'd0);
    in_valid = 1'b0;
    #2;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_count", 64'(illegal_count), 64'd0);
    repeat (2) step();
    reset = 1'b0;
    idle(2);

    // back-to-back R-type AND then SLT
    out_ready = 1'b1;
    push(2'd2, 6'd0, 6'h24, 1'b0, 32'hF0F0_0000, 32'h0FF0_0000, 16'd0);
    push(2'd2, 6'd0, 6'h2a, 1'b0, 32'hF0F0_0000, 32'h0FF0_0000, 16'd0);
    @(negedge clock);
    chk("rtype_slt_ctl", 64'(out_control), 64'h7);
    idle(3);

    // ori and addi with imm 0x8001
    push(2'd3, 6'h0d, 6'd0, 1'b1, 32'h1234, 32'h5555, 16'h8001);
    @(negedge clock);
    chk("ori_b", 64'(out_b), 64'h0000_8001);
    chk("ori_ctl", 64'(out_control), 64'h1);
    push(2'd3, 6'h08, 6'd0, 1'b1, 32'h1234, 32'h5555, 16'h8001);
    @(negedge clock);
    chk("addi_b", 64'(out_b), 64'hFFFF_8001);
    chk("addi_ctl", 64'(out_control), 64'h2);
    idle(3);

    // backpressure: third push held while full
    out_ready = 1'b0;
    push(2'd0, 6'd0, 6'd0, 1'b0, 32'h11, 32'h1, 16'd0);
    push(2'd1, 6'd0, 6'd0, 1'b0, 32'h22, 32'h2, 16'd0);
    drive(2'd0, 6'd0, 6'd0, 1'b0, 32'h33, 32'h3, 16'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_head_a", 64'(out_a), 64'h11);
      step();
    end
    out_ready = 1'b1;
    wait_acc();
    idle(4);

    // flush at occupancy 2 with in_valid high
    out_ready = 1'b0;
    push(2'd0, 6'd0, 6'd0, 1'b0, 32'h44, 32'h4, 16'd0);
    push(2'd0, 6'd0, 6'd0, 1'b0, 32'h55, 32'h5, 16'd0);
    drive(2'd2, 6'd0, 6'h3f, 1'b0, 32'h66, 32'h6, 16'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    chk("flush2_valid", 64'(out_valid), 64'd0);
    chk("flush2_ready", 64'(in_ready), 64'd1);
    chk("flush2_count", 64'(illegal_count), 64'd0);
    step();

    // flush at occupancy 1 while an illegal input could be accepted
    push(2'd0, 6'd0, 6'd0, 1'b0, 32'h77, 32'h7, 16'd0);
    drive(2'd2, 6'd0, 6'h3f, 1'b0, 32'h88, 32'h8, 16'd0);
    flush = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    chk("flush1_valid", 64'(out_valid), 64'd0);
    chk("flush1_count", 64'(illegal_count), 64'd0);
    idle(3);

    // illegal funct, 300 times
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++)
      push(2'd2, 6'd0, 6'h3f, 1'b0, $urandom, $urandom, 16'd0);
    idle(3);
    @(negedge clock);
    chk("illegal_saturated", 64'(illegal_count), 64'd255);
    step();

    // asynchronous reset between edges at occupancy 1
    out_ready = 1'b0;
    push(2'd1, 6'd0, 6'd0, 1'b0, 32'h99, 32'h9, 16'd0);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_ready", 64'(in_ready), 64'd1);
    chk("arst_zero", 64'(out_a | out_b | 32'(out_control)), 64'd0);
    chk("arst_count", 64'(illegal_count), 64'd0);
    q.delete();
    ill_model = 0;
    prev_hold = 0;
    pend = 0;
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    push(2'd2, 6'd0, 6'h25, 1'b0, 32'hA, 32'h5, 16'd0);
    @(negedge clock);
    chk("post_reset_ctl", 64'(out_control), 64'h1);
    step();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush = ($urandom % 40) == 0;
      in_alu_op = 2'($urandom);
      in_opcode = pick_opc();
      in_funct = pick_fn();
      in_alu_src = 1'($urandom);
      in_rs_data = $urandom;
      in_rt_data = $urandom;
      in_imm = 16'($urandom);
      step();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(5);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
